led_matrix_scanner: RTL
=======================

Name: led_matrix_scanner

Overview:
- Parametrised row-scanning driver for multiplexed LED matrix boards. Generalises the 16x16x2 board driver to configurable rows, columns and colour channels.
- Owns its own row counter and dwell timer, and inserts anti-ghosting blanking between rows.
- Double-buffers frames through a valid/ready handshake, so a new frame is displayed only at a frame boundary (no tearing).
- Sits between game/render logic and the GPIO pin-packing wrapper.

Parameters:
- ROWS, 16, number of scanned rows (>=2).
- COLS, 16, pixels per row per channel.
- CHANNELS, 2, colour channels (0=red, 1=green on the current board).
- FREQDIV, 15, row dwell = 2^FREQDIV clock cycles, blanking included (>=1).
- BLANK_CYCLES, 4, cycles with outputs blanked at the start of each row (< 2^FREQDIV).

Ports:
- CLK  input  1  system clock.
- RST_N  input  1  asynchronous active-low reset.
- Enable  input  1  1=scan; 0=hold the current row, outputs blanked.
- FrameValid  input  1  Pixels holds a complete new frame.
- FrameReady  output  1  pending buffer free; a frame is accepted when FrameValid&&FrameReady.
- Pixels  input  CHANNELS*ROWS*COLS  bit index (k*ROWS+r)*COLS+c = channel k, row r, column c.
- RowSelect  output  $clog2(ROWS)  row currently driven.
- ColData  output  CHANNELS*COLS  column drive; channel k at [k*COLS +: COLS].
- OutEn  output  1  1 while ColData is valid (DRIVE state).
- FrameStart  output  1  one-cycle pulse when row 0 begins its BLANK phase.

Behaviour:
- Reset (async assert, sync release):
  - outputs: RowSelect=0, ColData=0, OutEn=0, FrameStart=0, FrameReady=1.
  - internal: display buffer=0, pending buffer empty, dwell counter=0, state=IDLE.
- FSM: IDLE -> BLANK -> DRIVE -> BLANK ...
  - IDLE: leave on the first cycle Enable=1; go to BLANK at row 0 and pulse FrameStart.
  - BLANK: lasts BLANK_CYCLES cycles; OutEn=0, ColData=0.
  - DRIVE: lasts 2^FREQDIV-BLANK_CYCLES cycles; OutEn=1.
  - End of DRIVE: RowSelect increments and wraps ROWS-1 -> 0; state returns to BLANK.
- Dwell counter is FREQDIV bits wide and free-running while Enable=1; it wraps naturally at 2^FREQDIV.
- Enable=0: counter and RowSelect freeze, OutEn=0, ColData=0. Scanning resumes from the frozen count. The FSM never returns to IDLE except through reset.
- Column mapping is mirrored for board wiring: ColData[k*COLS+j] = display[k][RowSelect][COLS-1-j].
- ColData and OutEn are registered. During DRIVE they reflect RowSelect from the same cycle (no extra latency visible at the row boundary).
- Handshake:
  - When FrameValid&&FrameReady, Pixels are captured into the pending buffer and FrameReady drops the next cycle.
  - Pixels need only be stable in the accepting cycle.
- Swap: on the cycle RowSelect wraps to 0 (and on the IDLE->BLANK exit), a full pending buffer is copied into the display buffer and FrameReady returns to 1 the next cycle.
  - Simultaneous swap and accept in one cycle is impossible, because FrameReady=0 while pending is full.
- FrameValid held with FrameReady=0: no capture, no error.
- Reset mid-frame: everything returns to reset values immediately, and any pending frame is discarded.

Optional Feature:
- Macro LED_SCANNER_PWM_EN.
- When defined:
  - Adds input Brightness[3:0].
  - Within DRIVE, OutEn=1 only while (drive-phase cycle index >> (FREQDIV-4)) < Brightness. This needs FREQDIV>=4.
  - Brightness=15 gives near-full duty; Brightness=0 gives OutEn=0 at all times.
  - ColData is gated identically to OutEn.
- When undefined: no Brightness port, full duty in DRIVE.

Test Plan:
- Reset/IDLE: RST_N=0, then release with Enable=0 -> RowSelect=0, OutEn=0, FrameReady=1, FrameStart never pulses.
- Scan timing (FREQDIV=3, BLANK_CYCLES=2, ROWS=4):
  - Enable=1 -> FrameStart pulses once.
  - Each row gives 2 cycles OutEn=0 then 6 cycles OutEn=1.
  - RowSelect sequence is 0,1,2,3,0; FrameStart pulses again at the wrap.
- Mapping: load a frame with only channel 1, row 2, column 0 set -> during row 2 DRIVE, ColData[COLS+COLS-1]=1 and all other bits 0; other rows give ColData=0.
- Double-buffer:
  - Accept frame A mid-frame -> FrameReady=0 and the display is unchanged until the row wrap.
  - After the wrap, row 0 shows A and FrameReady=1.
  - A second FrameValid during the busy period is not captured.
- Enable pause: deassert Enable in DRIVE of row 1 for 20 cycles -> OutEn=0 and RowSelect=1 throughout; on resume the remaining dwell completes with no skipped rows.
- Async reset mid-DRIVE with a pending frame: RST_N low -> all outputs 0 in the same cycle, FrameReady=1; the pending frame is never displayed.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// Row-scanning LED matrix driver: dwell timer, anti-ghost blanking, double-buffered frames.
// Optional PWM brightness gating is enabled by defining LED_SCANNER_PWM_EN (needs FREQDIV >= 4).
module led_matrix_scanner #(
    parameter int ROWS         = 16,
    parameter int COLS         = 16,
    parameter int CHANNELS     = 2,
    parameter int FREQDIV      = 15,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            Enable,
    input  logic                            FrameValid,
    output logic                            FrameReady,
    input  logic [CHANNELS*ROWS*COLS-1:0]   Pixels,
`ifdef LED_SCANNER_PWM_EN
    input  logic [3:0]                      Brightness,
`endif
    output logic [$clog2(ROWS)-1:0]         RowSelect,
    output logic [CHANNELS*COLS-1:0]        ColData,
    output logic                            OutEn,
    output logic                            FrameStart,
    output logic [1:0]                      DbgState
);

    localparam int                  ROW_W       = $clog2(ROWS);
    localparam logic [FREQDIV-1:0]  LP_BLANK    = FREQDIV'(BLANK_CYCLES);
    localparam logic [FREQDIV-1:0]  LP_CNT_MAX  = '1;
    localparam logic [ROW_W-1:0]    LP_LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t                          r_state, w_state_next;
    logic [FREQDIV-1:0]              r_cnt, w_cnt_next, w_cnt_inc;
    logic [ROW_W-1:0]                r_row, w_row_next;
    logic [CHANNELS*COLS-1:0]        r_col_data, w_col_data_next;
    logic                            r_out_en, w_out_en_next;
    logic                            r_frame_start, w_frame_start_next;
    logic                            w_swap;
    logic                            w_accept;
    logic [CHANNELS*ROWS*COLS-1:0]   r_disp;
    logic [CHANNELS*ROWS*COLS-1:0]   r_pend;
    logic                            r_pend_full;
    logic [COLS-1:0]                 w_disp_arr [CHANNELS][ROWS];
    logic [CHANNELS*COLS-1:0]        w_mapped;

    // Columns are mirrored because the board wires column 0 to the last shift position.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            assign w_disp_arr[k][r] = r_disp[(k*ROWS + r)*COLS +: COLS];
        end
        for (genvar j = 0; j < COLS; j++) begin : g_col
            assign w_mapped[k*COLS + j] = w_disp_arr[k][r_row][COLS-1-j];
        end
    end

    assign w_cnt_inc = r_cnt + 1'b1;

    // Phase is a pure function of the dwell count: [0, BLANK) blanks, the rest drives.
    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_row_next         = r_row;
        w_frame_start_next = 1'b0;
        w_swap             = 1'b0;
        if (Enable) begin
            if (r_state == S_IDLE) begin
                w_state_next       = S_BLANK;
                w_row_next         = '0;
                w_frame_start_next = 1'b1;
                w_swap             = 1'b1;
            end else begin
                w_cnt_next   = w_cnt_inc;
                w_state_next = (w_cnt_inc < LP_BLANK) ? S_BLANK : S_DRIVE;
                if (r_cnt == LP_CNT_MAX) begin
                    if (r_row == LP_LAST_ROW) begin
                        w_row_next         = '0;
                        w_frame_start_next = 1'b1;
                        w_swap             = 1'b1;
                    end else begin
                        w_row_next = r_row + 1'b1;
                    end
                end
            end
        end
    end

`ifdef LED_SCANNER_PWM_EN
    logic [FREQDIV-1:0] w_drive_idx;
    logic               w_pwm_on;
    assign w_drive_idx = w_cnt_next - LP_BLANK;
    assign w_pwm_on    = (w_drive_idx[FREQDIV-1 -: 4] < Brightness);
`else
    logic               w_pwm_on;
    assign w_pwm_on    = 1'b1;
`endif

    // Row only changes on entering BLANK, so the mapped row is already valid on DRIVE entry.
    always_comb begin
        w_out_en_next   = Enable && (w_state_next == S_DRIVE) && w_pwm_on;
        w_col_data_next = w_out_en_next ? w_mapped : '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_row         <= '0;
            r_col_data    <= '0;
            r_out_en      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_row         <= w_row_next;
            r_col_data    <= w_col_data_next;
            r_out_en      <= w_out_en_next;
            r_frame_start <= w_frame_start_next;
        end
    end

    // Handshake: a frame transfers on any edge where FrameValid && FrameReady are both high;
    // FrameReady is simply "pending buffer empty", so it never depends on FrameValid.
    assign w_accept = FrameValid && !r_pend_full;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_disp      <= '0;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
        end else if (w_accept) begin
            r_pend      <= Pixels;
            r_pend_full <= 1'b1;
        end else if (w_swap && r_pend_full) begin
            r_disp      <= r_pend;
            r_pend_full <= 1'b0;
        end
    end

    assign FrameReady = !r_pend_full;
    assign RowSelect  = r_row;
    assign ColData    = r_col_data;
    assign OutEn      = r_out_en;
    assign FrameStart = r_frame_start;
    assign DbgState   = r_state;

endmodule
